simple_uart_rx: RTL and testbench
=================================

SIMPLE_UART_RX -- requirements
Module: simple_uart_rx

Interface
REQ-001 Parameter DATA_N_BIT, default 8, number of data bits per frame.
REQ-002 Parameter BAUD_RATE, default 10, line bit rate in bit/s.
REQ-003 Parameter F_CLK_Hz, default 100, clock frequency in Hz; CLK_PER_BIT = F_CLK_Hz/BAUD_RATE (integer, >= 4).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 async_rst_n  input  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
REQ-006 uart_din  input  1  serial line, idle high, asynchronous to clk.
REQ-007 dout  output  DATA_N_BIT  received data word.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-010 parity_err  output  1  parity status of the word in dout, valid while dout_valid.
REQ-011 frame_err  output  1  stop-bit status of the word in dout, valid while dout_valid.
REQ-012 overrun  output  1  one-cycle pulse: unconsumed word overwritten.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 Frame format SHALL be: start bit (0), DATA_N_BIT data bits LSB first, even-parity bit (XOR of data bits), stop bit (1), each CLK_PER_BIT clocks long.
REQ-015 uart_din SHALL pass through a two-flop synchronizer (reset value 1); all further references use the synchronized line rxs.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a single bit counter clk_cnt and bit index bit_cnt SHALL drive it.
REQ-017 IDLE: on rxs==0 SHALL go to START with clk_cnt=0, bit_cnt=0.
REQ-018 START: at clk_cnt==CLK_PER_BIT/2-1, rxs==0 SHALL go to DATA with clk_cnt=0; rxs==1 SHALL return to IDLE (glitch rejected, no output change).
REQ-019 DATA: at clk_cnt==CLK_PER_BIT-1 SHALL store rxs into data bit bit_cnt and clear clk_cnt; after bit DATA_N_BIT-1 SHALL go to PARITY.
REQ-020 PARITY: at clk_cnt==CLK_PER_BIT-1 SHALL record par_bad = rxs XOR (XOR of received data) and go to STOP with clk_cnt=0.
REQ-021 STOP: at clk_cnt==CLK_PER_BIT-1 SHALL sample rxs, go directly to IDLE (mid stop bit), and on the next edge load dout, parity_err=par_bad, frame_err=!rxs, dout_valid=1.
REQ-022 A frame with frame_err or parity_err SHALL still be delivered; errors are flags only.
REQ-023 dout_valid SHALL clear on the cycle after dout_valid && dout_ready; dout, parity_err, frame_err SHALL stay stable while dout_valid is high and unaccepted.
REQ-024 Completion while dout_valid=1 and dout_ready=0 SHALL overwrite dout/flags, keep dout_valid=1, pulse overrun for one cycle.
REQ-025 Completion in the same cycle as an accept SHALL load the new word with dout_valid=1 and no overrun.
REQ-026 After STOP, a low rxs in IDLE SHALL start the next frame immediately (back-to-back frames supported).
REQ-027 clk_cnt SHALL be $clog2(CLK_PER_BIT)+1 bits wide and never exceed CLK_PER_BIT-1.

Reset
REQ-028 While async_rst_n==0: state=IDLE, clk_cnt=0, bit_cnt=0, synchronizer=1, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no word delivered; after release the receiver SHALL wait for a new high-to-low start.

Verification
REQ-030 Frame 0xA5, parity 0, stop 1, dout_ready=1 -> one word dout=0xA5, dout_valid high one cycle, parity_err=0, frame_err=0.
REQ-031 Frame 0x01 with parity bit 0 -> dout=0x01, parity_err=1, frame_err=0.
REQ-032 Frame 0x3C, parity 0, stop bit 0 -> dout=0x3C, frame_err=1, parity_err=0.
REQ-033 Low pulse of CLK_PER_BIT/2-2 clocks on idle line -> no dout_valid, busy returns to 0.
REQ-034 Two back-to-back frames 0x11 then 0x22, dout_ready=0 -> dout=0x22, dout_valid=1, overrun pulses once; then dout_ready=1 -> dout_valid=0 next cycle.
REQ-035 async_rst_n pulsed low during data bit 4 of frame 0xFF -> all outputs 0 immediately, no word delivered; following frame 0x5A received correctly.

Source files
------------

// File: rtl/simple_uart_rx.sv
// UART receiver: start / DATA_N_BIT data (LSB first) / even parity / stop,
// oversampled at CLK_PER_BIT clocks per bit with a single-entry output register.
module simple_uart_rx #(
    parameter int unsigned DATA_N_BIT = 8,
    parameter int unsigned BAUD_RATE  = 10,
    parameter int unsigned F_CLK_Hz   = 100
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  uart_din,
    output logic [DATA_N_BIT-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned CLK_PER_BIT = F_CLK_Hz / BAUD_RATE;
    localparam int unsigned CNT_W       = $clog2(CLK_PER_BIT) + 1;
    localparam int unsigned BIT_W       = (DATA_N_BIT > 1) ? $clog2(DATA_N_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_N_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                  state_q,    state_d;
    logic [CNT_W-1:0]        clk_cnt_q,  clk_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_N_BIT-1:0]   shift_q,    shift_d;
    logic                    par_bad_q,  par_bad_d;
    logic                    stop_bit_q, stop_bit_d;
    logic                    done_q,     done_d;
    logic [1:0]              sync_q;

    logic [DATA_N_BIT-1:0]   dout_q,     dout_d;
    logic                    valid_q,    valid_d;
    logic                    perr_q,     perr_d;
    logic                    ferr_q,     ferr_d;
    logic                    ovr_q,      ovr_d;
    logic                    busy_q,     busy_d;

    logic                    rxs;

    assign rxs = sync_q[1];

    // Next-state, bit sampling and output-register update
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        stop_bit_d = stop_bit_q;
        done_d     = 1'b0;
        dout_d     = dout_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d   = S_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                // Re-check at mid start bit so short low glitches are dropped
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rxs;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    par_bad_d = rxs ^ (^shift_q);
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a following start edge is not missed
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d  = '0;
                    stop_bit_d = rxs;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        if (done_q) begin
            dout_d  = shift_q;
            perr_d  = par_bad_q;
            ferr_d  = !stop_bit_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !dout_ready;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bit_q <= 1'b1;
            done_q     <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_din};
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            stop_bit_q <= stop_bit_d;
            done_q     <= done_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_simple_uart_rx.sv
// Directed bench for simple_uart_rx: clean, parity-error, framing-error,
// glitch, overrun and mid-frame reset scenarios at 10 clocks per bit.
module tb_simple_uart_rx;

    localparam int unsigned CPB = 10;

    logic       clk;
    logic       async_rst_n;
    logic       uart_din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors;
    int checks;

    int         valid_cycles;
    int         ovr_pulses;
    logic [7:0] cap_dout;
    logic       cap_perr;
    logic       cap_ferr;

    simple_uart_rx #(
        .DATA_N_BIT(8),
        .BAUD_RATE (10),
        .F_CLK_Hz  (100)
    ) dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .uart_din   (uart_din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe delivered words and overrun pulses away from the active edge
    initial begin
        valid_cycles = 0;
        ovr_pulses   = 0;
        cap_dout     = 8'h00;
        cap_perr     = 1'b0;
        cap_ferr     = 1'b0;
    end
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            valid_cycles = valid_cycles + 1;
            cap_dout     = dout;
            cap_perr     = parity_err;
            cap_ferr     = frame_err;
        end
        if (overrun === 1'b1) ovr_pulses = ovr_pulses + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        uart_din = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        uart_din = 1'b1;
    endtask

    task automatic test_reset();
        async_rst_n = 1'b0;
        uart_din    = 1'b1;
        dout_ready  = 1'b1;
        idle(3);
        checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        async_rst_n = 1'b1;
        idle(10);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", dout_valid); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic par,
                              input logic stp, input logic exp_perr, input logic exp_ferr);
        int v0;
        v0 = valid_cycles;
        dout_ready = 1'b1;
        send_frame(d, par, stp);
        idle(30);
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL %s_valid_cycles: got %0d want 1", name, valid_cycles - v0); end
        checks++; if (cap_dout !== d)          begin errors++; $display("FAIL %s_dout: got %h want %h", name, cap_dout, d); end
        checks++; if (cap_perr !== exp_perr)   begin errors++; $display("FAIL %s_perr: got %b want %b", name, cap_perr, exp_perr); end
        checks++; if (cap_ferr !== exp_ferr)   begin errors++; $display("FAIL %s_ferr: got %b want %b", name, cap_ferr, exp_ferr); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = valid_cycles;
        uart_din = 1'b0;
        idle(CPB / 2 - 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %b want 1", busy); end
        uart_din = 1'b1;
        idle(20);
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_no_word: got %0d want 0", valid_cycles - v0); end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = ovr_pulses;
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        checks++; if (dout !== 8'h11)          begin errors++; $display("FAIL b2b_first_dout: got %h want 11", dout); end
        checks++; if (dout_valid !== 1'b1)     begin errors++; $display("FAIL b2b_first_valid: got %b want 1", dout_valid); end
        checks++; if (ovr_pulses - o0 !== 0)   begin errors++; $display("FAIL b2b_first_ovr: got %0d want 0", ovr_pulses - o0); end
        send_frame(8'h22, 1'b0, 1'b1);
        idle(5);
        checks++; if (dout !== 8'h22)          begin errors++; $display("FAIL b2b_second_dout: got %h want 22", dout); end
        checks++; if (dout_valid !== 1'b1)     begin errors++; $display("FAIL b2b_second_valid: got %b want 1", dout_valid); end
        checks++; if (ovr_pulses - o0 !== 1)   begin errors++; $display("FAIL b2b_ovr_pulses: got %0d want 1", ovr_pulses - o0); end
        checks++; if (overrun !== 1'b0)        begin errors++; $display("FAIL b2b_ovr_cleared: got %b want 0", overrun); end
        dout_ready = 1'b1;
        idle(1);
        checks++; if (dout_valid !== 1'b0)     begin errors++; $display("FAIL b2b_accept: got %b want 0", dout_valid); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        v0 = valid_cycles;
        dout_ready = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        uart_din = 1'b1;
        idle(CPB / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        #2 async_rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL rst_mid_dout: got %h want 00", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", dout_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_mid_perr: got %b want 0", parity_err); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_mid_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL rst_mid_ovr: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        idle(3);
        async_rst_n = 1'b1;
        idle(150);
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL rst_mid_no_word: got %0d want 0", valid_cycles - v0); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL rst_mid_idle: got %b want 0", busy); end
        test_frame("after_rst_5a", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        async_rst_n = 1'b0;
        uart_din    = 1'b1;
        dout_ready  = 1'b1;
        test_reset();
        test_frame("good_a5",   8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        test_frame("parity_01", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        test_frame("frame_3c",  8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        test_glitch();
        test_back_to_back();
        idle(20);
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
